// File: rtl/chnl_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// chnl_pattern_gen_if
//   Valid/ready channel between a pattern generator (master) and one mcdt
//   input channel (slave). The slave also reports its free FIFO slots.
//
//   ch_data_o   : word presented by the generator
//   ch_valid_o  : generator has a word on ch_data_o
//   ch_ready_i  : slave accepts the word at the next rising edge
//   ch_margin_i : free FIFO slots reported by the slave
//
//   The _o/_i suffixes are from the generator's point of view.
// ---------------------------------------------------------------------------
interface chnl_pattern_gen_if #(
  parameter int DW = 32,
  parameter int MW = 6
);
  logic [DW-1:0] ch_data_o;
  logic          ch_valid_o;
  logic          ch_ready_i;
  logic [MW-1:0] ch_margin_i;

  modport master (
    output ch_data_o,
    output ch_valid_o,
    input  ch_ready_i,
    input  ch_margin_i
  );

  modport slave (
    input  ch_data_o,
    input  ch_valid_o,
    output ch_ready_i,
    output ch_margin_i
  );
endinterface

// File: rtl/chnl_pattern_gen.sv
// ---------------------------------------------------------------------------
// chnl_pattern_gen
//   Per-channel traffic generator. A run emits NUM_WORDS words of value
//   (BASE + i) mod 2^DW on a valid/ready channel. Features on top of the
//   plain word stream: a programmable idle gap between accepted words,
//   throttling on the slave's reported margin, abort, and run status.
//
//   Ports
//     clk_i       : clock, rising edge
//     rstn_i      : asynchronous active-low reset
//     start_i     : start a run (only looked at while idle)
//     abort_i     : end the current run early
//     gap_cfg_i   : idle cycles after each accepted word (captured at the
//                   handshake)
//     ch          : channel interface, master side
//     busy_o      : a run is in progress (including its done cycle)
//     done_o      : one-cycle pulse when a run ends, completed or aborted
//     sent_cnt_o  : words accepted in the current or last run
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module chnl_pattern_gen #(
  parameter int            DW         = 32,
  parameter int            MW         = 6,
  parameter logic [DW-1:0] BASE       = DW'(32'h00C0_0000),
  parameter int            NUM_WORDS  = 100,
  parameter int            GW         = 4,
  parameter int            MARGIN_MIN = 1,
  parameter int            CW         = $clog2(NUM_WORDS + 1)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [GW-1:0]          gap_cfg_i,
  chnl_pattern_gen_if.master     ch,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CW-1:0]          sent_cnt_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0] LAST_IDX     = CW'(NUM_WORDS - 1);
  localparam logic [MW-1:0] MARGIN_MIN_W = MW'(MARGIN_MIN);

  logic [1:0]    state;
  logic [CW-1:0] idx;         // index of the word being (or about to be) presented
  logic [CW-1:0] idx_nxt;
  logic [GW-1:0] gap_cnt;     // idle cycles still to spend in S_GAP
  logic          abort_pend;  // abort seen while a word was stalled on ready
  logic          margin_ok;
  logic          is_last;

  assign idx_nxt   = idx + CW'(1);
  assign margin_ok = (ch.ch_margin_i >= MARGIN_MIN_W);
  assign is_last   = (idx == LAST_IDX);

  function automatic logic [DW-1:0] word_of(input logic [CW-1:0] i);
    return BASE + DW'(i);  // wrap-around past 2^DW is intentional
  endfunction

  // NOTE: a single clocked process owns every register, so all updates use
  // non-blocking assignments; no state leaks through combinational paths.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= S_IDLE;
      idx           <= '0;
      gap_cnt       <= '0;
      abort_pend    <= 1'b0;
      ch.ch_valid_o <= 1'b0;
      ch.ch_data_o  <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      sent_cnt_o    <= '0;
    end else begin
      done_o <= 1'b0;

      case (state)
        S_IDLE: begin
          // abort_i is deliberately ignored here, so start wins a tie
          if (start_i) begin
            state      <= S_SEND;
            busy_o     <= 1'b1;
            idx        <= '0;
            sent_cnt_o <= '0;
            abort_pend <= 1'b0;
          end
        end

        S_SEND: begin
          if (ch.ch_valid_o) begin
            // A presented word is never withdrawn: margin and abort only
            // matter once it has been accepted.
            if (ch.ch_ready_i) begin
              sent_cnt_o <= sent_cnt_o + CW'(1);
              if (is_last || abort_pend || abort_i) begin
                state         <= S_DONE;
                done_o        <= 1'b1;
                abort_pend    <= 1'b0;
                ch.ch_valid_o <= 1'b0;
                ch.ch_data_o  <= '0;
              end else begin
                idx <= idx_nxt;
                if (gap_cfg_i == '0) begin
                  // back-to-back: next word goes out straight away if allowed
                  ch.ch_valid_o <= margin_ok;
                  ch.ch_data_o  <= margin_ok ? word_of(idx_nxt) : '0;
                end else begin
                  state         <= S_GAP;
                  gap_cnt       <= gap_cfg_i;
                  ch.ch_valid_o <= 1'b0;
                  ch.ch_data_o  <= '0;
                end
              end
            end else if (abort_i) begin
              abort_pend <= 1'b1;
            end
          end else if (abort_i) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else if (margin_ok) begin
            ch.ch_valid_o <= 1'b1;
            ch.ch_data_o  <= word_of(idx);
          end
        end

        S_GAP: begin
          if (abort_i) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end else if (gap_cnt <= GW'(1)) begin
            // Last idle cycle: raise valid on this edge so the low stretch
            // is exactly the captured gap length.
            state         <= S_SEND;
            ch.ch_valid_o <= margin_ok;
            ch.ch_data_o  <= margin_ok ? word_of(idx) : '0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chnl_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_chnl_pattern_gen
//   Two generator instances: a 32-bit one (4 words from 00C00000) and an
//   8-bit one (4 words from FE, exercising wrap-around and mid-run reset).
//   The 32-bit instance is watched every cycle by a run-level model: the
//   expected word index, whether a stalled word must be held, when done_o
//   must pulse and what sent_cnt_o must read.
// ---------------------------------------------------------------------------
module tb_chnl_pattern_gen;

  localparam int NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: DW=32 ----------------
  logic       a_rstn, a_start, a_abort;
  logic [3:0] a_gap;
  logic       a_busy, a_done;
  logic [2:0] a_cnt;

  chnl_pattern_gen_if #(.DW(32), .MW(6)) ifa ();

  chnl_pattern_gen #(
    .DW(32), .MW(6), .BASE(32'h00C0_0000), .NUM_WORDS(NW), .GW(4), .MARGIN_MIN(1)
  ) dut_a (
    .clk_i(clk), .rstn_i(a_rstn), .start_i(a_start), .abort_i(a_abort),
    .gap_cfg_i(a_gap), .ch(ifa), .busy_o(a_busy), .done_o(a_done),
    .sent_cnt_o(a_cnt)
  );

  // ---------------- instance B: DW=8 -----------------
  logic       b_rstn, b_start, b_abort;
  logic [3:0] b_gap;
  logic       b_busy, b_done;
  logic [2:0] b_cnt;

  chnl_pattern_gen_if #(.DW(8), .MW(6)) ifb ();

  chnl_pattern_gen #(
    .DW(8), .MW(6), .BASE(8'hFE), .NUM_WORDS(NW), .GW(4), .MARGIN_MIN(1)
  ) dut_b (
    .clk_i(clk), .rstn_i(b_rstn), .start_i(b_start), .abort_i(b_abort),
    .gap_cfg_i(b_gap), .ch(ifb), .busy_o(b_busy), .done_o(b_done),
    .sent_cnt_o(b_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_a(input int i);
    return 32'h00C0_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] word_b(input int i);
    return 32'((254 + i) % 256);
  endfunction

  // ---------------- run model for instance A ----------------
  int m_idx    = 0;   // words accepted so far in this run
  bit m_run    = 0;   // between start and end of run
  bit m_done_exp = 0; // done_o expected high in the current cycle
  bit m_abort_seen = 0;
  bit m_hold   = 0;   // previous cycle had valid without ready
  int m_cyc    = 0;   // cycle number, 0 = first cycle after start edge
  int fv_cyc   = -1;  // first cycle with valid high
  int lx_cyc   = -1;  // cycle of last transfer
  int done_cyc = -1;  // cycle in which done_o is expected
  bit prev_valid = 0;
  bit prev_margin_ok = 0;
  bit after_xfer = 0;
  int low_cnt  = 0;
  int g_lat    = 0;

  // Drive one cycle of inputs on A, check its current outputs against the
  // model, then advance the model across the coming edge.
  task automatic cyc_a(input bit st, input bit rdy, input int mg, input bit ab);
    bit v, xfer, done_next, started;
    a_start = st;
    a_abort = ab;
    ifa.ch_ready_i  = rdy;
    ifa.ch_margin_i = 6'(mg);
    v = ifa.ch_valid_o;

    if (!m_run) check("a_idle_valid", 32'(v), 32'd0);
    if (m_run && m_cyc == 0) check("a_start_latency", 32'(v), 32'd0);
    if (v) check("a_data", ifa.ch_data_o, word_a(m_idx));
    if (m_hold) check("a_hold_valid", 32'(v), 32'd1);
    check("a_cnt", 32'(a_cnt), 32'(m_idx));
    check("a_done", 32'(a_done), 32'(m_done_exp));
    check("a_busy", 32'(a_busy), 32'(m_run || m_done_exp));
    if (v && !prev_valid && m_run) begin
      check("a_rise_margin", 32'(prev_margin_ok), 32'd1);
      if (after_xfer) check("a_gap_len", 32'(low_cnt >= g_lat), 32'd1);
      if (fv_cyc < 0) fv_cyc = m_cyc;
    end
    if (!v && after_xfer && m_run) low_cnt++;

    xfer      = v && rdy;
    done_next = 1'b0;
    if (m_run) begin
      if (xfer)          done_next = (m_idx == NW - 1) || m_abort_seen || ab;
      else if (!v && ab) done_next = 1'b1;
      else if (v && ab)  m_abort_seen = 1'b1;
    end
    m_hold = v && !rdy;
    if (xfer) begin
      m_idx++;
      lx_cyc     = m_cyc;
      g_lat      = int'(a_gap);
      low_cnt    = 0;
      after_xfer = 1'b1;
    end
    prev_valid     = v;
    prev_margin_ok = (mg >= 1);
    started        = !m_run && !m_done_exp && st;
    m_done_exp     = 1'b0;
    if (done_next) begin
      m_run      = 1'b0;
      m_done_exp = 1'b1;
      done_cyc   = m_cyc + 1;
    end
    if (started) begin
      m_run        = 1'b1;
      m_idx        = 0;
      m_abort_seen = 1'b0;
      m_hold       = 1'b0;
      m_cyc        = -1;
      fv_cyc       = -1;
      lx_cyc       = -1;
      done_cyc     = -1;
      after_xfer   = 1'b0;
    end
    @(posedge clk); #1;
    m_cyc++;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  logic [7:0] q_b[$];

  initial begin
    a_rstn = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_gap = '0;
    ifa.ch_ready_i = 1'b0; ifa.ch_margin_i = 6'd32;
    b_rstn = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_gap = '0;
    ifb.ch_ready_i = 1'b0; ifb.ch_margin_i = 6'd32;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(ifa.ch_valid_o), 32'd0);
    check("rst_data",  ifa.ch_data_o, 32'd0);
    check("rst_busy",  32'(a_busy), 32'd0);
    check("rst_done",  32'(a_done), 32'd0);
    check("rst_cnt",   32'(a_cnt), 32'd0);
    check("rst_b_valid", 32'(ifb.ch_valid_o), 32'd0);
    @(negedge clk);
    a_rstn = 1'b1;
    b_rstn = 1'b1;
    @(posedge clk); #1;

    // 1: back-to-back, ready always high
    cyc_a(1, 1, 32, 0);
    repeat (8) cyc_a(0, 1, 32, 0);
    check("t1_first_valid", 32'(fv_cyc), 32'd1);
    check("t1_last_xfer",   32'(lx_cyc), 32'd4);
    check("t1_done_cyc",    32'(done_cyc), 32'd5);
    check("t1_cnt",         32'(a_cnt), 32'd4);

    // 2: ready low for 3 cycles on word 1
    cyc_a(1, 1, 32, 0);
    cyc_a(0, 1, 32, 0);
    cyc_a(0, 1, 32, 0);
    for (int k = 0; k < 3; k++) begin
      check("t2_hold_data", ifa.ch_data_o, 32'h00C0_0001);
      cyc_a(0, 0, 32, 0);
    end
    repeat (6) cyc_a(0, 1, 32, 0);
    check("t2_done_cyc", 32'(done_cyc), 32'd8);
    check("t2_cnt",      32'(a_cnt), 32'd4);

    // 3: gap of 2 between words
    a_gap = 4'd2;
    cyc_a(1, 1, 32, 0);
    repeat (14) cyc_a(0, 1, 32, 0);
    a_gap = 4'd0;
    check("t3_first_valid", 32'(fv_cyc), 32'd1);
    check("t3_span",        32'(lx_cyc - fv_cyc + 1), 32'd10);
    check("t3_done_cyc",    32'(done_cyc), 32'd11);

    // 4: margin throttling
    cyc_a(1, 0, 0, 0);
    repeat (3) cyc_a(0, 0, 0, 0);
    cyc_a(0, 0, 1, 0);
    cyc_a(0, 0, 0, 0);
    check("t4_held_no_margin", 32'(ifa.ch_valid_o), 32'd1);
    cyc_a(0, 0, 0, 0);
    cyc_a(0, 1, 0, 0);
    check("t4_no_new_word", 32'(ifa.ch_valid_o), 32'd0);
    cyc_a(0, 1, 0, 0);
    repeat (12) cyc_a(0, 1, 32, 0);
    check("t4_first_valid", 32'(fv_cyc), 32'd4);
    check("t4_cnt",         32'(a_cnt), 32'd4);

    // 5a: abort while word 2 stalls
    cyc_a(1, 1, 32, 0);
    repeat (3) cyc_a(0, 1, 32, 0);
    cyc_a(0, 0, 32, 1);
    check("t5_pending_valid", 32'(ifa.ch_valid_o), 32'd1);
    cyc_a(0, 0, 32, 0);
    repeat (4) cyc_a(0, 1, 32, 0);
    check("t5_done_cyc", 32'(done_cyc), 32'd6);
    check("t5_cnt",      32'(a_cnt), 32'd3);

    // 5b: abort during the gap
    a_gap = 4'd3;
    cyc_a(1, 1, 32, 0);
    repeat (3) cyc_a(0, 1, 32, 0);
    cyc_a(0, 1, 32, 1);
    repeat (3) cyc_a(0, 1, 32, 0);
    a_gap = 4'd0;
    check("t5b_done_cyc", 32'(done_cyc), 32'd4);
    check("t5b_cnt",      32'(a_cnt), 32'd1);

    // 5c: abort in SEND before any valid
    cyc_a(1, 1, 0, 0);
    cyc_a(0, 1, 0, 0);
    cyc_a(0, 1, 0, 1);
    repeat (3) cyc_a(0, 1, 32, 0);
    check("t5c_done_cyc", 32'(done_cyc), 32'd2);
    check("t5c_cnt",      32'(a_cnt), 32'd0);

    // abort alone in IDLE does nothing; start with abort still starts
    cyc_a(0, 1, 32, 1);
    cyc_a(0, 1, 32, 0);
    cyc_a(1, 1, 32, 1);
    repeat (8) cyc_a(0, 1, 32, 0);
    check("t_startabort_done", 32'(done_cyc), 32'd5);
    check("t_startabort_cnt",  32'(a_cnt), 32'd4);

    // randomized runs: ready, margin and gap vary every cycle
    for (int r = 0; r < 8; r++) begin
      a_gap = 4'($urandom_range(0, 3));
      cyc_a(1, 1, 32, 0);
      for (int c = 0; c < 400 && (m_run || m_done_exp); c++) begin
        a_gap = 4'($urandom_range(0, 3));
        cyc_a(0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 0);
      end
      check("rand_finished", 32'(m_run || m_done_exp), 32'd0);
      check("rand_cnt",      32'(a_cnt), 32'd4);
    end
    a_gap = 4'd0;

    // 6: DW=8 wrap-around
    ifb.ch_ready_i = 1'b1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (ifb.ch_valid_o && ifb.ch_ready_i) q_b.push_back(ifb.ch_data_o);
      @(posedge clk); #1;
    end
    check("t6_nwords", 32'(q_b.size()), 32'd4);
    for (int k = 0; k < q_b.size() && k < 4; k++) check("t6_word", 32'(q_b[k]), word_b(k));
    check("t6_cnt", 32'(b_cnt), 32'd4);

    // 6: reset mid-run, then restart from word 0
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_pre_reset_valid", 32'(ifb.ch_valid_o), 32'd1);
    #2;
    b_rstn = 1'b0;
    #1;
    check("t6_rst_valid", 32'(ifb.ch_valid_o), 32'd0);
    check("t6_rst_data",  32'(ifb.ch_data_o), 32'd0);
    check("t6_rst_busy",  32'(b_busy), 32'd0);
    check("t6_rst_cnt",   32'(b_cnt), 32'd0);
    @(negedge clk);
    b_rstn = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    @(posedge clk); #1;
    check("t6_restart_valid", 32'(ifb.ch_valid_o), 32'd1);
    check("t6_restart_data",  32'(ifb.ch_data_o), word_b(0));
    repeat (8) @(posedge clk);
    #1;
    check("t6_restart_cnt", 32'(b_cnt), 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/chnl_pattern_gen.md
Name: chnl_pattern_gen

Overview:
- Synthesizable, parametrised per-channel traffic generator that replaces the behavioural channel initiator task.
- Emits NUM_WORDS words of value BASE+i on a valid/ready channel, one block instance per mcdt input channel.
- Beyond the behavioural initiator, it adds:
  - a programmable idle gap between words;
  - margin-based throttling;
  - abort;
  - completion and word-count status.

Parameters:
- DW, 32, channel data width.
- MW, 6, width of the channel margin input.
- BASE, 32'h00C0_0000, value of word 0; truncated to DW bits.
- NUM_WORDS, 100, words per run (>=1).
- GW, 4, width of the idle-gap configuration.
- MARGIN_MIN, 1, minimum ch_margin_i required to raise valid for a new word.
- CW, $clog2(NUM_WORDS+1), word-counter width.

Ports:
- clk_i, in, 1, clock, all logic on the rising edge.
- rstn_i, in, 1, reset; one clock; reset is asynchronous and active-low.
- start_i, in, 1, start a run; sampled only in IDLE.
- abort_i, in, 1, end the run early.
- gap_cfg_i, in, GW, idle cycles inserted between accepted words; sampled at each handshake.
- ch_data_o, out, DW, channel data.
- ch_valid_o, out, 1, channel valid.
- ch_ready_i, in, 1, channel ready from the DUT.
- ch_margin_i, in, MW, free FIFO slots reported by the DUT.
- busy_o, out, 1, high in any state except IDLE.
- done_o, out, 1, one-cycle pulse when a run ends, whether completed or aborted.
- sent_cnt_o, out, CW, words accepted in the current or last run.

Behaviour:
- Reset values (all outputs registered): ch_valid_o=0, ch_data_o=0, busy_o=0, done_o=0, sent_cnt_o=0, state=IDLE, abort_pend=0.
- Handshake:
  - A transfer occurs at a posedge where ch_valid_o=1 and ch_ready_i=1.
  - Once valid is raised, ch_valid_o and ch_data_o are held stable until the transfer. Valid is never retracted, whatever the margin or abort inputs do.
- Word value: word i = (BASE + i) mod 2^DW. Wrap-around is silent.
- IDLE:
  - start_i=1 -> SEND; sent_cnt_o cleared to 0; index cleared to 0.
  - start_i is ignored in every other state.
- SEND:
  - While ch_valid_o=0: raise valid together with the word's data when ch_margin_i >= MARGIN_MIN. Otherwise keep valid low and re-evaluate every cycle.
  - Earliest valid is the cycle after start.
  - On a transfer, sent_cnt_o increments the same edge.
- Next state after a transfer:
  - Last word (index = NUM_WORDS-1), or abort_pend set, or abort_i=1 -> DONE; valid drops.
  - Else gap_cfg_i=0 -> stay in SEND. The next word is presented the following cycle if margin allows, giving back-to-back transfers with valid continuously high.
  - Else -> GAP; valid=0, data=0.
- GAP:
  - Valid stays low for exactly gap_cfg_i cycles, using the value latched at the handshake.
  - Then SEND with the next index.
  - abort_i in GAP -> DONE next edge.
- DONE:
  - done_o=1 and busy_o=1 for exactly one cycle, then IDLE.
  - sent_cnt_o holds its value until the next start.
- Abort:
  - abort_i while ch_valid_o=1 and no transfer: sets abort_pend; the pending word completes, then DONE.
  - abort_i in SEND with ch_valid_o=0: DONE next edge.
  - abort_i in IDLE: no effect.
- Simultaneous events:
  - Transfer plus abort_i at the same edge: the word is counted, then DONE.
  - start_i plus abort_i in IDLE: start wins; abort is ignored.
- Reset mid-run: everything returns to reset values immediately, including valid; a new start begins again at word 0.
- Latency:
  - Start to first valid: 1 cycle when margin is OK.
  - Last transfer to done_o: 1 cycle.

Test Plan:
1. BASE=32'h00C0_0000, NUM_WORDS=4, gap 0, ready=1, margin=32 -> data 00C00000..00C00003 on 4 consecutive valid cycles; done_o pulses the cycle after the last transfer; sent_cnt_o=4.
2. Backpressure: ready low for 3 cycles on word 1 -> valid and data 00C00001 held stable for 3 cycles; transfer on the 4th; no duplicated or skipped words.
3. gap_cfg_i=2 -> exactly 2 low-valid cycles between each transfer; 4 words finish in 10 cycles after the first valid.
4. Margin: MARGIN_MIN=1, margin=0 at start -> valid stays low; margin=1 -> valid rises next cycle. Margin dropping to 0 while valid is high -> valid is held until the transfer.
5. Abort: abort_i while word 2 is pending with ready=0 -> word 2 completes once ready=1; done_o pulses; sent_cnt_o=3. Abort during GAP -> done_o next cycle.
6. DW=8, BASE=8'hFE, NUM_WORDS=4 -> FE, FF, 00, 01. Reset asserted mid-run -> valid low immediately; restart emits FE first.
